spi_byte_rx: RTL and testbench
==============================

# spi_byte_rx

SPI slave receive front end for the LED cube controller. It synchronises the raw SPI pins (SCLK, MOSI, CS_n) and the D/C sideband pin into the system clock domain, then assembles MSB-first bytes. Each complete byte is presented for exactly one clock as a pulse together with its D/C flag. It sits directly upstream of the layer/RAM write controller, whose byte-ready, byte-data and D/C inputs it drives.

## Interface
- SYNC_STAGES, 2, number of flops in each input synchroniser; legal range 2..4.
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- spi_sclk_in  input  1  raw SPI clock, mode 0 (idle low, sample on rising edge); asynchronous to clk_in.
- spi_mosi_in  input  1  raw SPI data, MSB first.
- spi_cs_n_in  input  1  raw chip select, active low.
- dc_in  input  1  raw D/C pin: 0 = command byte, 1 = data byte.
- byte_rdy_out  output  1  one-cycle pulse; byte_data_out and dc_out are valid in this cycle.
- byte_data_out  output  8  last completed byte; holds its value between pulses.
- dc_out  output  1  D/C value captured with the last completed byte; holds its value between pulses.

## Operation
- One clock; reset is asynchronous and active-low. Ports are clk_in and rst_n_in.
- Synchronisers:
  - sclk, mosi, cs_n and dc each pass through SYNC_STAGES flops.
  - All four use the same depth so they stay mutually aligned.
  - Reset values: sclk 0, mosi 0, cs_n 1, dc 0.
- Edge detect:
  - One extra register holds the previous synchronised sclk.
  - rise = sclk_s & ~sclk_q.
  - Falling edges are ignored.
- States, implicit in cs_s:
  - IDLE (cs_s = 1): bit_cnt is held at 0, shift register is cleared, rises are ignored.
  - ACTIVE (cs_s = 0): each rise is a bit sample.
- On each rise in ACTIVE:
  - shift register ← {shift[6:0], mosi_s}.
  - bit_cnt (3 bits) increments and wraps 7 → 0.
- On the rise with bit_cnt = 7:
  - byte_data_out ← {shift[6:0], mosi_s}.
  - dc_out ← dc_s.
  - byte_rdy_out ← 1 for the next cycle only.
  - bit_cnt wraps to 0, so consecutive bytes stream with no gap while CS stays low.
- CS deassert in the middle of a byte:
  - The partial byte is discarded: no pulse, and byte_data_out/dc_out are unchanged.
  - bit_cnt returns to 0.
- Simultaneous events:
  - If cs_s = 1 in the same cycle as the 8th rise, IDLE wins and no pulse is generated.
  - If cs_s goes low in the same cycle as a rise, the rise counts as bit 0.
- Reset mid-byte: everything returns to reset values immediately, and the partial byte is lost.
- Outputs in reset: byte_rdy_out 0, byte_data_out 8'h00, dc_out 0.

## Timing
- Latency: byte_rdy_out rises on the (SYNC_STAGES + 2)-th clk_in edge after the raw 8th SCLK rising edge, with ±1 cycle of sampling uncertainty.
- byte_rdy_out is high for exactly 1 cycle per byte. The minimum spacing between pulses is 8 × (SCLK period in clk cycles).
- Input constraints:
  - SCLK high and low phases must each be ≥ SYNC_STAGES + 1 clk_in periods, i.e. f_sclk ≤ f_clk / (2·(SYNC_STAGES+1)).
  - MOSI and DC must be stable from 1 clk_in period before to SYNC_STAGES + 1 periods after the raw SCLK rise.
  - CS_n must fall ≥ SYNC_STAGES + 1 clk periods before the first SCLK rise.
- All outputs are registered; there is no combinational path from any input pin to any output.

## Structure
- Shared package cube_pkg:
  - Add SPI_SYNC_STAGES_DEF = 2.
  - CUBE0414 command byte constants live there. This block does not decode them but the bench uses them.
- Sub-module sync_ff:
  - Generic N-stage, W-bit synchroniser with an asynchronous active-low reset and a per-bit reset value parameter.
  - Instantiated once with W = 4, reset value 4'b0100 (cs_n bit = 1).
- The top level holds edge detect, bit_cnt, shift register and the output registers.
- Expected size is about 120–160 lines including sync_ff.

## Test plan
- **Single command byte.** CS low, send 0x2A with DC = 0 at f_sclk = f_clk/8 → one byte_rdy_out pulse, byte_data_out = 0x2A, dc_out = 0; no other pulses.
- **Streaming data.** With CS held low, send 0x2C (DC = 0) then 0x11, 0x22, 0x33 (DC = 1) → exactly 4 pulses, in order, with matching data and dc values 0, 1, 1, 1.
- **Abort and recovery.** Send 5 bits of 0xFF, raise CS, lower CS, send 0xA5 → no pulse for the partial byte; a single pulse with 0xA5.
- **Ignored clocks.** Toggle SCLK 16 times with CS high and random MOSI → no pulse; outputs keep their previous values.
- **Reset mid-byte.** Assert rst_n_in low after 4 bits of 0x3C, release, send 0x81 → outputs read 0x00/0/0 during reset; next pulse carries 0x81.
- **Maximum rate.** Run at f_sclk = f_clk/6 (SYNC_STAGES = 2) with 64 random bytes → all 64 received in order. A scoreboard checks the latency bound on every pulse.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared LED cube controller definitions.
// Holds the SPI front-end defaults and the CUBE0414 command byte values.
package cube_pkg;

  localparam int SPI_SYNC_STAGES_DEF = 2;

  // CUBE0414 command bytes, sent with D/C = 0.
  localparam logic [7:0] CMD_NOP        = 8'h00;
  localparam logic [7:0] CMD_COL_ADDR   = 8'h2A;
  localparam logic [7:0] CMD_PAGE_ADDR  = 8'h2B;
  localparam logic [7:0] CMD_MEM_WRITE  = 8'h2C;

  typedef struct packed {
    logic dc;
    logic cs_n;
    logic mosi;
    logic sclk;
  } spi_pins_t;

  localparam spi_pins_t SPI_PINS_RST = '{dc: 1'b0, cs_n: 1'b1, mosi: 1'b0, sclk: 1'b0};

endpackage

// File: rtl/sync_ff.sv
// Generic N-stage, W-bit synchroniser with a per-bit reset value.
// Latency: N clk_in cycles.
// Backpressure: none, free-running.
module sync_ff #(
  parameter int             N       = 2,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [N-1:0][W-1:0] stage_q;
  logic [N-1:0][W-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[N-2:0], d_in};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stage_q <= {N{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_out = stage_q[N-1];

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receiver: synchronises the pins and assembles MSB-first bytes.
// Latency: byte_rdy_out about SYNC_STAGES+1..+2 clk_in cycles after the raw 8th SCLK rise.
// Backpressure: none; the consumer must accept every one-cycle byte_rdy_out pulse.
module spi_byte_rx
  import cube_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       spi_sclk_in,
  input  logic       spi_mosi_in,
  input  logic       spi_cs_n_in,
  input  logic       dc_in,
  output logic       byte_rdy_out,
  output logic [7:0] byte_data_out,
  output logic       dc_out
);

  spi_pins_t pins_raw;
  spi_pins_t pins_s;

  logic       sclk_q,      sclk_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [6:0] shift_q,     shift_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       dc_q,        dc_d;
  logic       byte_rdy_q,  byte_rdy_d;
  logic       rise;

  assign pins_raw = '{dc: dc_in, cs_n: spi_cs_n_in, mosi: spi_mosi_in, sclk: spi_sclk_in};

  // All four pins share one synchroniser so they stay cycle-aligned.
  sync_ff #(
    .N       (SYNC_STAGES),
    .W       (4),
    .RST_VAL (SPI_PINS_RST)
  ) u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d_in     (pins_raw),
    .q_out    (pins_s)
  );

  assign rise = pins_s.sclk & ~sclk_q;

  always_comb begin
    sclk_d      = pins_s.sclk;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_data_d = byte_data_q;
    dc_d        = dc_q;
    byte_rdy_d  = 1'b0;

    // CS high dominates, so a deassert on the 8th rise drops the byte.
    if (pins_s.cs_n) begin
      bit_cnt_d = 3'd0;
      shift_d   = 7'd0;
    end else if (rise) begin
      shift_d   = {shift_q[5:0], pins_s.mosi};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_data_d = {shift_q, pins_s.mosi};
        dc_d        = pins_s.dc;
        byte_rdy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sclk_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_data_q <= 8'h00;
      dc_q        <= 1'b0;
      byte_rdy_q  <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_data_q <= byte_data_d;
      dc_q        <= dc_d;
      byte_rdy_q  <= byte_rdy_d;
    end
  end

  assign byte_rdy_out  = byte_rdy_q;
  assign byte_data_out = byte_data_q;
  assign dc_out        = dc_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: scoreboard of expected bytes, checked on each pulse.
module tb_spi_byte_rx;
  import cube_pkg::*;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n_in;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       dc;
  logic       byte_rdy_out;
  logic [7:0] byte_data_out;
  logic       dc_out;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   cyc      = 0;
  int   base;
  logic prev_rdy = 1'b0;

  spi_byte_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n_in),
    .spi_sclk_in   (spi_sclk),
    .spi_mosi_in   (spi_mosi),
    .spi_cs_n_in   (spi_cs_n),
    .dc_in         (dc),
    .byte_rdy_out  (byte_rdy_out),
    .byte_data_out (byte_data_out),
    .dc_out        (dc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest expected byte and its latency window.
  always @(negedge clk) begin
    if (byte_rdy_out === 1'b1) begin
      n_pulses++;
      check_eq("pulse_width", prev_rdy, 0);
      check_eq("pulse_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("data", byte_data_out, e.data);
        check_eq("dc", dc_out, e.dc);
        check_eq("latency_ok", (cyc - e.cyc >= SYNC + 1) && (cyc - e.cyc <= SYNC + 3), 1);
      end
    end
    prev_rdy = byte_rdy_out;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int half, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = b[7-i];
      dc       = d;
      wait_clk(half);
      spi_sclk = 1'b1;
      if (i == 7) sb.push_back('{data: b, dc: d, cyc: cyc});
      wait_clk(half);
    end
  endtask

  task automatic start_frame();
    spi_cs_n = 1'b0;
    wait_clk(SYNC + 2);
  endtask

  task automatic end_frame(input int half);
    spi_sclk = 1'b0;
    wait_clk(half);
    spi_cs_n = 1'b1;
    wait_clk(SYNC + 3);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) wait_clk(1);
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    dc       = 1'b0;
    wait_clk(4);
    check_eq("rst_rdy", byte_rdy_out, 0);
    check_eq("rst_data", byte_data_out, 8'h00);
    check_eq("rst_dc", dc_out, 0);
    rst_n_in = 1'b1;
    wait_clk(4);

    // Single command byte at f_clk/8
    base = n_pulses;
    start_frame();
    send_bits(CMD_COL_ADDR, 1'b0, 4, 8);
    end_frame(4);
    drain("single_drain");
    check_eq("single_count", n_pulses - base, 1);

    // Streaming: one command then three data bytes under one CS
    base = n_pulses;
    start_frame();
    send_bits(CMD_MEM_WRITE, 1'b0, 4, 8);
    send_bits(8'h11, 1'b1, 4, 8);
    send_bits(8'h22, 1'b1, 4, 8);
    send_bits(8'h33, 1'b1, 4, 8);
    end_frame(4);
    drain("stream_drain");
    check_eq("stream_count", n_pulses - base, 4);

    // Abort after 5 bits, then a full byte
    base = n_pulses;
    start_frame();
    send_bits(8'hFF, 1'b0, 4, 5);
    end_frame(4);
    check_eq("abort_count", n_pulses - base, 0);
    check_eq("abort_data_hold", byte_data_out, 8'h33);
    check_eq("abort_dc_hold", dc_out, 1);
    start_frame();
    send_bits(8'hA5, 1'b0, 4, 8);
    end_frame(4);
    drain("recover_drain");
    check_eq("recover_count", n_pulses - base, 1);

    // SCLK activity with CS high is ignored
    base = n_pulses;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      spi_sclk = 1'b0;
      wait_clk(4);
      spi_sclk = 1'b1;
      wait_clk(4);
    end
    spi_sclk = 1'b0;
    wait_clk(SYNC + 4);
    check_eq("idle_count", n_pulses - base, 0);
    check_eq("idle_data_hold", byte_data_out, 8'hA5);
    check_eq("idle_dc_hold", dc_out, 0);

    // Reset in the middle of a byte
    base = n_pulses;
    start_frame();
    send_bits(8'h3C, 1'b1, 4, 4);
    rst_n_in = 1'b0;
    #2;
    check_eq("midrst_rdy", byte_rdy_out, 0);
    check_eq("midrst_data", byte_data_out, 8'h00);
    check_eq("midrst_dc", dc_out, 0);
    spi_sclk = 1'b0;
    wait_clk(3);
    rst_n_in = 1'b1;
    wait_clk(SYNC + 3);
    send_bits(8'h81, 1'b1, 4, 8);
    end_frame(4);
    drain("midrst_drain");
    check_eq("midrst_count", n_pulses - base, 1);

    // Maximum rate: f_clk/6, 64 random bytes
    base = n_pulses;
    start_frame();
    for (int i = 0; i < 64; i++) begin
      send_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3, 8);
    end
    end_frame(3);
    drain("maxrate_drain");
    check_eq("maxrate_count", n_pulses - base, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
